// File: rtl/axi_rd_pkg.sv
// Shared definitions for the two-master AXI read arbiter.
// Contents:
//   state_t      - arbiter FSM encoding (IDLE / ADDR / DATA)
//   *_W          - fixed AXI field widths (arlen, arsize, arburst, rresp)
//   BEAT_W/MAX   - width and saturation value of the R beat counter
//   RESP_*       - AXI response codes
package axi_rd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  // One more bit than arlen so a full 256-beat burst is representable.
  localparam int                BEAT_W   = 9;
  localparam logic [BEAT_W-1:0] BEAT_MAX = 9'd256;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant, purely combinational.
// Ports:
//   req  [1:0] - request vector
//   last       - index of the master served most recently
//   gnt  [1:0] - one-hot grant, 0 when nothing is requested
// The master that was not served last wins whenever it requests;
// otherwise the sole requester wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  logic pref;

  always_comb begin
    gnt  = 2'b00;
    pref = ~last;
    if (req[pref]) begin
      gnt[pref] = 1'b1;
    end else if (req[last]) begin
      gnt[last] = 1'b1;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read port (s_axi_*) between two read masters (m_*).
// Master 0 is the debug dump reader, master 1 the feature/classifier reader.
// A whole burst is granted at a time, round-robin, and the grant is held
// from AR acceptance until the rlast beat completes.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   m_ar*  / m_arvalid       - per-master AR channel, master i at [i*W +: W]
//   m_arready                - per-master AR ready
//   m_r*   / m_rvalid        - per-master R channel (data fields broadcast)
//   m_rready                 - per-master R ready
//   s_axi_ar* / s_axi_r*     - the single RAM read port
//   grant                    - one-hot active grant, 0 when idle
//   busy                     - FSM not in IDLE
//   len_err                  - sticky: a burst ended with beats != arlen+1
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready; ready and valid are routed
// combinationally from the registered state and grant, so the only master
// that ever sees ready/valid is the granted one, and only in the phase
// (ADDR for AR, DATA for R) that owns that channel.
module axi_rd_arbiter
  import axi_rd_pkg::*;
#(
  parameter int ID_WIDTH       = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_BIT_WIDTH = 256,
  parameter int REQ_NUM        = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [REQ_NUM*ID_WIDTH-1:0]        m_arid,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0]      m_araddr,
  input  logic [REQ_NUM*LEN_W-1:0]           m_arlen,
  input  logic [REQ_NUM*SIZE_W-1:0]          m_arsize,
  input  logic [REQ_NUM*BURST_W-1:0]         m_arburst,
  input  logic [REQ_NUM-1:0]                 m_arvalid,
  output logic [REQ_NUM-1:0]                 m_arready,
  output logic [REQ_NUM*ID_WIDTH-1:0]        m_rid,
  output logic [REQ_NUM*DATA_BIT_WIDTH-1:0]  m_rdata,
  output logic [REQ_NUM*RESP_W-1:0]          m_rresp,
  output logic [REQ_NUM-1:0]                 m_rlast,
  output logic [REQ_NUM-1:0]                 m_rvalid,
  input  logic [REQ_NUM-1:0]                 m_rready,
  output logic [ID_WIDTH-1:0]                s_axi_arid,
  output logic [ADDR_WIDTH-1:0]              s_axi_araddr,
  output logic [LEN_W-1:0]                   s_axi_arlen,
  output logic [SIZE_W-1:0]                  s_axi_arsize,
  output logic [BURST_W-1:0]                 s_axi_arburst,
  output logic                               s_axi_arvalid,
  input  logic                               s_axi_arready,
  input  logic [ID_WIDTH-1:0]                s_axi_rid,
  input  logic [DATA_BIT_WIDTH-1:0]          s_axi_rdata,
  input  logic [RESP_W-1:0]                  s_axi_rresp,
  input  logic                               s_axi_rlast,
  input  logic                               s_axi_rvalid,
  output logic                               s_axi_rready,
  output logic [REQ_NUM-1:0]                 grant,
  output logic                               busy,
  output logic                               len_err
);

  state_t              state_q, state_d;
  logic [REQ_NUM-1:0]  grant_q, grant_d;
  logic [REQ_NUM-1:0]  arb_gnt;
  logic                last_q, last_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                len_err_q, len_err_d;
  logic                g;
  logic                ar_hs;
  logic                r_hs;

  rr_arb2 u_rr_arb2 (
    .req  (m_arvalid),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // Index of the granted master; only meaningful while grant_q is non-zero.
  assign g = grant_q[1];

  // AR fields always follow the grant; arvalid gates them to the RAM.
  assign s_axi_arid    = g ? m_arid[ID_WIDTH +: ID_WIDTH]       : m_arid[0 +: ID_WIDTH];
  assign s_axi_araddr  = g ? m_araddr[ADDR_WIDTH +: ADDR_WIDTH] : m_araddr[0 +: ADDR_WIDTH];
  assign s_axi_arlen   = g ? m_arlen[LEN_W +: LEN_W]            : m_arlen[0 +: LEN_W];
  assign s_axi_arsize  = g ? m_arsize[SIZE_W +: SIZE_W]         : m_arsize[0 +: SIZE_W];
  assign s_axi_arburst = g ? m_arburst[BURST_W +: BURST_W]      : m_arburst[0 +: BURST_W];

  assign s_axi_arvalid = (state_q == ADDR) && m_arvalid[g];
  assign m_arready     = (state_q == ADDR) ? (grant_q & {REQ_NUM{s_axi_arready}}) : '0;

  // Stray R beats outside DATA are never acknowledged.
  assign s_axi_rready  = (state_q == DATA) && m_rready[g];
  assign m_rvalid      = (state_q == DATA) ? (grant_q & {REQ_NUM{s_axi_rvalid}}) : '0;

  // R payload is a zero-latency broadcast; only rvalid is steered.
  assign m_rid   = {REQ_NUM{s_axi_rid}};
  assign m_rdata = {REQ_NUM{s_axi_rdata}};
  assign m_rresp = {REQ_NUM{s_axi_rresp}};
  assign m_rlast = {REQ_NUM{s_axi_rlast}};

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign len_err = len_err_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    len_d     = len_q;
    beat_d    = beat_q;
    len_err_d = len_err_q;
    case (state_q)
      IDLE: begin
        if (|m_arvalid) begin
          grant_d = arb_gnt;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) begin
          len_d   = s_axi_arlen;
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          if (beat_q != BEAT_MAX) begin
            beat_d = beat_q + 1'b1;
          end
          if (s_axi_rlast) begin
            // beat_q counts the beats before this one, so a correct burst
            // reaches rlast with beat_q == arlen.
            if (beat_q != {1'b0, len_q}) begin
              len_err_d = 1'b1;
            end
            last_d  = g;
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= 1'b1;
      len_q     <= '0;
      beat_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      len_err_q <= len_err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: a behavioural RAM, two master
// drivers with per-master expected-beat queues, and a rule-based arbitration
// model tracking who should be granted and whether len_err should be set.
module tb_axi_rd_arbiter;

  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 256;
  localparam int EW  = IDW + 2 + 1 + DW;
  localparam int CW  = EW;

  typedef struct {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [7:0]     len;
    int             stall_at;
  } req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  wire  [2*IDW-1:0] m_arid;
  wire  [2*AW-1:0]  m_araddr;
  wire  [15:0]      m_arlen;
  wire  [5:0]       m_arsize;
  wire  [3:0]       m_arburst;
  wire  [1:0]       m_arvalid;
  logic [1:0]       m_arready;
  logic [2*IDW-1:0] m_rid;
  logic [2*DW-1:0]  m_rdata;
  logic [3:0]       m_rresp;
  logic [1:0]       m_rlast;
  logic [1:0]       m_rvalid;
  wire  [1:0]       m_rready;
  logic [IDW-1:0]   s_axi_arid;
  logic [AW-1:0]    s_axi_araddr;
  logic [7:0]       s_axi_arlen;
  logic [2:0]       s_axi_arsize;
  logic [1:0]       s_axi_arburst;
  logic             s_axi_arvalid;
  logic             s_axi_arready;
  logic [IDW-1:0]   s_axi_rid;
  logic [DW-1:0]    s_axi_rdata;
  logic [1:0]       s_axi_rresp;
  logic             s_axi_rlast;
  logic             s_axi_rvalid;
  logic             s_axi_rready;
  logic [1:0]       grant;
  logic             busy;
  logic             len_err;

  axi_rd_arbiter #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_BIT_WIDTH(DW), .REQ_NUM(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .grant(grant), .busy(busy), .len_err(len_err)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a, input int b);
    return {8{a + 32'(b)}};
  endfunction

  // ---------------- RAM model ----------------
  int ram_short = -1;  // when >= 0, next burst ends after ram_short+1 beats

  initial begin
    bit             ar_hs, r_hs;
    logic [AW-1:0]  a, ram_addr;
    logic [IDW-1:0] id, ram_id;
    logic [7:0]     l;
    bit             ram_have;
    int             ram_beat, ram_nbeats;
    ram_have = 0; ram_beat = 0; ram_nbeats = 0; ram_addr = '0; ram_id = '0;
    s_axi_arready = 0; s_axi_rvalid = 0; s_axi_rlast = 0;
    s_axi_rdata = '0; s_axi_rid = '0; s_axi_rresp = 2'b00;
    forever begin
      @(negedge clk);
      ar_hs = s_axi_arvalid && s_axi_arready;
      r_hs  = s_axi_rvalid && s_axi_rready;
      a = s_axi_araddr; id = s_axi_arid; l = s_axi_arlen;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ram_have = 0; s_axi_arready = 0; s_axi_rvalid = 0; s_axi_rlast = 0;
        continue;
      end
      if (ar_hs) begin
        ram_have = 1; ram_beat = 0; ram_addr = a; ram_id = id;
        ram_nbeats = (ram_short >= 0) ? ram_short + 1 : int'(l) + 1;
        ram_short = -1;
      end
      if (r_hs) begin
        ram_beat++;
        if (ram_beat == ram_nbeats) ram_have = 0;
      end
      s_axi_arready = !ram_have && ($urandom_range(0, 2) != 0);
      if (ram_have) begin
        if (!(s_axi_rvalid && !r_hs)) s_axi_rvalid = ($urandom_range(0, 3) != 0);
        s_axi_rdata = ram_word(ram_addr, ram_beat);
        s_axi_rid   = ram_id;
        s_axi_rresp = 2'b00;
        s_axi_rlast = (ram_beat == ram_nbeats - 1);
      end else begin
        s_axi_rvalid = 0;
        s_axi_rlast  = 0;
      end
    end
  end

  // ---------------- master drivers ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_m
    req_t            req_q[$];
    logic [EW-1:0]   exp_q[$];
    logic [IDW-1:0]  id;
    logic [AW-1:0]   addr;
    logic [7:0]      len;
    logic            arv;
    logic            rrd;

    assign m_arid[gi*IDW +: IDW] = id;
    assign m_araddr[gi*AW +: AW] = addr;
    assign m_arlen[gi*8 +: 8]    = len;
    assign m_arsize[gi*3 +: 3]   = 3'd5;
    assign m_arburst[gi*2 +: 2]  = 2'b01;
    assign m_arvalid[gi]         = arv;
    assign m_rready[gi]          = rrd;

    initial begin
      req_t          r;
      int            cyc, stall, nbeat;
      bit            got_last, abort, ok;
      logic [EW-1:0] e;
      id = '0; addr = '0; len = '0; arv = 0; rrd = 0;
      forever begin
        @(posedge clk);
        #1;
        if (!rst_n || req_q.size() == 0) continue;
        r = req_q.pop_front();
        id = r.id; addr = r.addr; len = r.len; arv = 1;
        cyc = 0; abort = 0;
        forever begin
          @(negedge clk);
          if (!rst_n) begin abort = 1; break; end
          if (m_arready[gi]) break;
          cyc++;
          if (cyc > 2000) begin
            ok = 0;
            check_eq("ar_accepted", ok, 1);
            abort = 1;
            break;
          end
        end
        @(posedge clk);
        #1;
        arv = 0;
        got_last = 0; cyc = 0; stall = 0; nbeat = 0;
        while (!abort && !got_last) begin
          rrd = (stall > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (!rst_n) begin
            abort = 1;
          end else begin
            if (stall > 0) begin
              check_eq("stall_rready", s_axi_rready, 0);
              stall--;
            end
            if (m_rvalid[gi] && rrd) begin
              if (exp_q.size() == 0) begin
                check_eq("beat_extra", CW'(exp_q.size()), 1);
              end else begin
                e = exp_q.pop_front();
                check_eq("rbeat", {m_rid[gi*IDW +: IDW], m_rresp[gi*2 +: 2],
                                   m_rlast[gi], m_rdata[gi*DW +: DW]}, e);
              end
              nbeat++;
              if (m_rlast[gi]) got_last = 1;
              if (nbeat == r.stall_at) stall = 5;
            end
            cyc++;
            if (cyc > 3000) begin
              ok = 0;
              check_eq("burst_done", ok, 1);
              abort = 1;
            end
          end
          @(posedge clk);
          #1;
        end
        rrd = 0;
        if (abort) begin
          arv = 0;
          exp_q.delete();
        end
      end
    end
  end

  // ---------------- arbitration / length reference model ----------------
  bit   exp_len_err = 0;
  int   mon_beats = 0;
  int   served_q[$];

  initial begin
    int   last_served, cur_m, cur_len, w;
    bit   m_idle, pend_g, pend_end;
    last_served = 1; cur_m = 0; cur_len = 0; w = 0;
    m_idle = 1; pend_g = 0; pend_end = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_served = 1; m_idle = 1; pend_g = 0; pend_end = 0;
        mon_beats = 0; exp_len_err = 0;
        continue;
      end
      if (pend_g) begin
        check_eq("grant", grant, CW'(2'b01 << cur_m));
        check_eq("busy_on", busy, 1);
        pend_g = 0;
      end
      if (pend_end) begin
        check_eq("grant_release", grant, 0);
        check_eq("busy_off", busy, 0);
        check_eq("len_err", len_err, exp_len_err);
        pend_end = 0;
      end
      // Whoever was not served last wins if requesting, else the sole requester.
      if (m_idle && m_arvalid != 2'b00) begin
        w = m_arvalid[1 - last_served] ? 1 - last_served : last_served;
        cur_m = w; m_idle = 0; pend_g = 1;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        check_eq("araddr", s_axi_araddr, m_araddr[cur_m*AW +: AW]);
        check_eq("arlen", s_axi_arlen, m_arlen[cur_m*8 +: 8]);
        check_eq("arsize_burst", {s_axi_arsize, s_axi_arburst}, {3'd5, 2'b01});
        check_eq("arready_route", m_arready, CW'(2'b01 << cur_m));
        cur_len = int'(m_arlen[cur_m*8 +: 8]);
        mon_beats = 0;
      end
      if (s_axi_rvalid && s_axi_rready) begin
        check_eq("rvalid_route", m_rvalid, CW'(2'b01 << cur_m));
        mon_beats++;
        if (s_axi_rlast) begin
          if (mon_beats != cur_len + 1) exp_len_err = 1;
          served_q.push_back(cur_m);
          last_served = cur_m;
          m_idle = 1;
          pend_end = 1;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic push_req(input int m, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                          input int len, input int nbeats, input int stall_at);
    req_t r;
    r.id = id; r.addr = addr; r.len = 8'(len); r.stall_at = stall_at;
    for (int i = 0; i < nbeats; i++) begin
      if (m == 0) g_m[0].exp_q.push_back({id, 2'b00, (i == nbeats - 1), ram_word(addr, i)});
      else        g_m[1].exp_q.push_back({id, 2'b00, (i == nbeats - 1), ram_word(addr, i)});
    end
    if (m == 0) g_m[0].req_q.push_back(r);
    else        g_m[1].req_q.push_back(r);
  endtask

  task automatic wait_idle(input int limit);
    int cyc;
    bit ok;
    cyc = 0; ok = 0;
    while (cyc <= limit) begin
      @(negedge clk);
      if (g_m[0].req_q.size() == 0 && g_m[1].req_q.size() == 0 &&
          g_m[0].exp_q.size() == 0 && g_m[1].exp_q.size() == 0 &&
          !g_m[0].arv && !g_m[1].arv && !busy) begin
        ok = 1;
        break;
      end
      cyc++;
    end
    check_eq("idle_reached", ok, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_served(input string tag, input int n, input logic [7:0] pat);
    check_eq({tag, "_count"}, CW'(served_q.size()), CW'(n));
    for (int i = 0; i < n && i < served_q.size(); i++) begin
      check_eq(tag, CW'(served_q[i]), CW'(pat[i]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_grant"}, grant, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_len_err"}, len_err, 0);
    check_eq({tag, "_s_arvalid"}, s_axi_arvalid, 0);
    check_eq({tag, "_s_rready"}, s_axi_rready, 0);
    check_eq({tag, "_m_arready"}, m_arready, 0);
    check_eq({tag, "_m_rvalid"}, m_rvalid, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  bit run_done = 0;

  initial begin
    int  cyc;
    bit  started;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1;

    // Single master 0, arlen=3 at 0x20.
    served_q.delete();
    push_req(0, 4'h1, 32'h20, 3, 4, -1);
    wait_idle(2000);
    check_served("t1_order", 1, 8'b0);

    // Both masters together straight after reset, then master 0 again.
    do_reset();
    served_q.delete();
    push_req(0, 4'h2, 32'h100, 1, 2, -1);
    push_req(0, 4'h3, 32'h200, 2, 3, -1);
    push_req(1, 4'h4, 32'h300, 2, 3, -1);
    wait_idle(3000);
    check_served("t2_order", 3, 8'b010);

    // Master 1 withholds rready for 5 cycles mid-burst.
    push_req(1, 4'h5, 32'h400, 7, 8, 2);
    wait_idle(3000);

    // RAM ends an arlen=3 burst after 2 beats; len_err must stick.
    ram_short = 1;
    push_req(0, 4'h6, 32'h500, 3, 2, -1);
    wait_idle(2000);
    check_eq("len_err_set", len_err, 1);
    push_req(1, 4'h7, 32'h600, 1, 2, -1);
    wait_idle(2000);
    check_eq("len_err_sticky", len_err, 1);

    // Master 0 keeps requesting; master 1 joins once and must be next.
    served_q.delete();
    push_req(0, 4'h8, 32'h700, 2, 3, -1);
    push_req(0, 4'h9, 32'h800, 0, 1, -1);
    push_req(0, 4'hA, 32'h900, 1, 2, -1);
    cyc = 0;
    while (!busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    push_req(1, 4'hB, 32'hA00, 0, 1, -1);
    wait_idle(4000);
    check_served("t6_order", 4, 8'b0010);

    // Reset in the middle of master 1's 16-beat burst after master 0 went last.
    push_req(0, 4'hC, 32'hB00, 0, 1, -1);
    wait_idle(2000);
    push_req(1, 4'hD, 32'hC00, 15, 16, -1);
    cyc = 0; started = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      if (busy && mon_beats >= 3) begin started = 1; break; end
      cyc++;
    end
    check_eq("burst_started", started, 1);
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1;
    served_q.delete();
    push_req(0, 4'hE, 32'hD00, 1, 2, -1);
    push_req(1, 4'hF, 32'hE00, 1, 2, -1);
    wait_idle(3000);
    check_served("post_reset_order", 2, 8'b10);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      int pick, ln;
      pick = $urandom_range(0, 2);
      if (pick != 1) begin
        ln = $urandom_range(0, 7);
        push_req(0, 4'($urandom_range(0, 15)), $urandom & 32'hFFFF_FFE0, ln, ln + 1, -1);
      end
      if (pick != 0) begin
        ln = $urandom_range(0, 7);
        push_req(1, 4'($urandom_range(0, 15)), $urandom & 32'hFFFF_FFE0, ln, ln + 1, -1);
      end
      repeat ($urandom_range(0, 25)) @(posedge clk);
    end
    wait_idle(20000);

    run_done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    check_eq("watchdog_done", run_done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
